// File: rtl/mem_copy.sv
// mem_copy: block-copy engine driving the store/load port pair of a byte-wide
// memory. One byte moves every two clocks (LOAD then STORE).
// Optional feature: define MEM_COPY_MEMMOVE_EN to copy backward when the
// destination overlaps the tail of the source, giving memmove semantics.
module mem_copy #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              en_store,
  output logic [ADDR_W-1:0] addr_store,
  output logic [DATA_W-1:0] data_store,
  output logic              en_load,
  output logic [ADDR_W-1:0] addr_load,
  input  logic [DATA_W-1:0] data_load
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FIN} state_t;

  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cur_src, cur_dst;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   hold;
  logic                dir_back;
  logic                err_q;
  logic                zero_wait;
  logic                back;
  logic [ADDR_W-1:0]   last_off;

  assign last_off = len[ADDR_W-1:0] - ADDR_ONE;

`ifdef MEM_COPY_MEMMOVE_EN
  logic [ADDR_W-1:0] gap;
  assign gap  = dst - src;
  assign back = (dst != src) && ({1'b0, gap} < len);
`else
  assign back = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (len <= LEN_MAX)) state_nx = (len == '0) ? FIN : LOAD;
      LOAD:    state_nx = STORE;
      STORE:   state_nx = (cnt == CNT_ONE) ? FIN : LOAD;
      // A zero-length request dwells one extra cycle in FIN so done lands two
      // cycles after start, matching the pacing of a real copy.
      FIN:     if (!zero_wait) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side and status outputs, forced to zero when not enabled
  always_comb begin
    busy       = (state == LOAD) || (state == STORE);
    en_load    = (state == LOAD);
    addr_load  = en_load ? cur_src : '0;
    en_store   = (state == STORE);
    addr_store = en_store ? cur_dst : '0;
    data_store = en_store ? hold : '0;
    done       = (state == FIN) && !zero_wait;
    err        = err_q;
  end

  // State, address pointers, byte counter and hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      cnt       <= '0;
      hold      <= '0;
      dir_back  <= 1'b0;
      err_q     <= 1'b0;
      zero_wait <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len > LEN_MAX) begin
              err_q <= 1'b1;
            end else begin
              cnt       <= len;
              dir_back  <= back;
              zero_wait <= (len == '0);
              cur_src   <= back ? src + last_off : src;
              cur_dst   <= back ? dst + last_off : dst;
            end
          end
        end
        LOAD: hold <= data_load;
        STORE: begin
          cur_src <= dir_back ? cur_src - ADDR_ONE : cur_src + ADDR_ONE;
          cur_dst <= dir_back ? cur_dst - ADDR_ONE : cur_dst + ADDR_ONE;
          cnt     <= cnt - CNT_ONE;
        end
        FIN: zero_wait <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
